seven_segment_scanner: RTL and testbench
========================================

SEVEN_SEGMENT_SCANNER -- requirements
Module: seven_segment_scanner

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (legal 1..8).
REQ-002 SHALL have parameter PRESCALE, default 50000, clock cycles per digit slot (legal >= 2).
REQ-003 SHALL have parameter GUARD, default 2, cycles at the start of each slot with all anodes off (legal 0..PRESCALE-1).
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port value  input  4*NUM_DIGITS  hex nibbles; nibble i drives digit i, digit 0 is least significant.
REQ-007 SHALL have port dp_in  input  NUM_DIGITS  decimal point request per digit, 1 = lit.
REQ-008 SHALL have port blank  input  NUM_DIGITS  forced blanking per digit, 1 = dark.
REQ-009 SHALL have port lz_en  input  1  enables leading-zero suppression.
REQ-010 SHALL have port an  output  NUM_DIGITS  anode enables, active-low, one-hot-zero.
REQ-011 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-012 SHALL have port dp  output  1  decimal point, active-low.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse when the last digit slot ends.

Function
REQ-014 SHALL count prescaler 0..PRESCALE-1; slot tick occurs on the cycle the prescaler equals PRESCALE-1.
REQ-015 SHALL advance the digit index on each tick, wrapping NUM_DIGITS-1 -> 0.
REQ-016 SHALL pulse frame_done on the tick where the index wraps to 0.
REQ-017 SHALL capture value, dp_in, blank and lz_en into shadow registers on the wrap tick only; mid-frame input changes SHALL NOT affect the current frame.
REQ-018 SHALL drive every output from registers; an/seg/dp change on the same edge as the index.
REQ-019 SHALL hold an all-ones (off), seg 7'h7F and dp 1 while the prescaler is below GUARD in every slot.
REQ-020 SHALL, after the guard, assert only an[index] low unless the digit is blanked.
REQ-021 SHALL decode nibbles with standard hex glyphs: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E.
REQ-022 SHALL treat digit i as blanked if shadow blank[i]=1, or if lz_en=1, i>0 and nibbles i..NUM_DIGITS-1 are all zero.
REQ-023 SHALL, for a blanked digit, keep its anode high, seg 7'h7F and dp 1 for the whole slot.
REQ-024 SHALL drive dp low in an unblanked slot iff shadow dp_in[index]=1.
REQ-025 SHALL keep the index, prescaler and shadow registers at fixed widths, clog2(NUM_DIGITS) (minimum 1) and clog2(PRESCALE) bits respectively.

Reset
REQ-026 SHALL, while reset=0, asynchronously force an all-ones, seg 7'h7F, dp 1, frame_done 0, index 0, prescaler 0 and shadow registers 0.
REQ-027 SHALL, after reset release, start at digit 0 with a guard interval and show zeros until the first wrap tick loads the shadows.
REQ-028 SHALL, when reset is asserted mid-slot, abandon the slot immediately with no partial-frame residue after release.

Structure
REQ-029 SHALL place the hex-to-segment table, the blank pattern 7'h7F and the anode-off constant in a shared package, seven_segment_pkg.
REQ-030 SHALL instantiate one combinational sub-module, seven_seg_hex_decoder (nibble in, 7-bit active-low glyph out).
REQ-031 SHALL target 120-400 lines of RTL.

Verification (NUM_DIGITS=4, PRESCALE=4, GUARD=1 unless stated)
REQ-032 SHALL cover this case: hold reset=0 -> an=4'b1111, seg=7'h7F, dp=1, frame_done=0; release -> first slot shows digit 0.
REQ-033 SHALL cover this case: value=16'h1234 loaded, lz_en=0 -> per slot, after 1 guard cycle: an=1110/seg 7'h19, an=1101/7'h30, an=1011/7'h24, an=0111/7'h79; frame_done once every 16 cycles.
REQ-034 SHALL cover this case: change value 16'h1234 -> 16'hABCD during slot 1 -> rest of frame still shows 3,2,1; next frame shows D,C,B,A.
REQ-035 SHALL cover this case: value=16'h0050, lz_en=1 -> slots 3 and 2 keep an all-ones; slot 1 shows 7'h12; slot 0 shows 7'h40; value=16'h0000 -> only digit 0 lit.
REQ-036 SHALL cover this case: blank=4'b0100, dp_in=4'b0001 -> digit 2 dark; dp=0 only in the digit-0 slot.
REQ-037 SHALL cover this case: assert reset mid-slot 2 -> outputs off on the same cycle with no clock edge; after release, scan restarts at digit 0.

Source files
------------

// File: rtl/seven_segment_pkg.sv
// rtl/seven_segment_pkg.sv - shared glyph table and display constants for the digit scanner
package seven_segment_pkg;

    // Segment pattern with every segment dark ({g,f,e,d,c,b,a}, active-low)
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Anode pattern with every digit off, sized for the widest legal display
    localparam int         MAX_DIGITS = 8;
    localparam logic [MAX_DIGITS-1:0] ANODE_OFF = 8'hFF;

    // Standard hex glyphs, active-low
    function automatic logic [6:0] hex_glyph(input logic [3:0] nibble);
        logic [6:0] glyph;
        glyph = SEG_BLANK;
        case (nibble)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            4'hF: glyph = 7'h0E;
            default: glyph = SEG_BLANK;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/seven_seg_hex_decoder.sv
// rtl/seven_seg_hex_decoder.sv - combinational nibble to active-low seven-segment glyph
module seven_seg_hex_decoder
    import seven_segment_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    // Pure table lookup; the scanner registers the result
    assign glyph = hex_glyph(nibble);

endmodule

// File: rtl/seven_segment_scanner.sv
// rtl/seven_segment_scanner.sv - multiplexed seven-segment scanner with guard, blanking and frame shadowing
module seven_segment_scanner
    import seven_segment_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 50000,
    parameter int GUARD      = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    lz_en,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PS_W  = $clog2(PRESCALE);

    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PS_W-1:0]       LAST_PS   = PS_W'(PRESCALE - 1);
    localparam logic [PS_W-1:0]       GUARD_PS  = PS_W'(GUARD);
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = ANODE_OFF[NUM_DIGITS-1:0];

    logic [PS_W-1:0]         presc, presc_nx;
    logic [IDX_W-1:0]        idx, idx_nx;
    logic [4*NUM_DIGITS-1:0] sh_value, sh_value_nx;
    logic [NUM_DIGITS-1:0]   sh_dp, sh_dp_nx;
    logic [NUM_DIGITS-1:0]   sh_blank, sh_blank_nx;
    logic                    sh_lz, sh_lz_nx;

    logic                    tick, wrap;
    logic                    upper_zero;
    logic [NUM_DIGITS-1:0]   digit_blank;
    logic [3:0]              nib_sel;
    logic [6:0]              glyph;
    logic [NUM_DIGITS-1:0]   an_nx;
    logic [6:0]              seg_nx;
    logic                    dp_nx;

    // Timebase: slot tick at the end of each prescaler period, frame wrap after the last digit
    always_comb begin
        tick        = (presc == LAST_PS);
        wrap        = tick && (idx == LAST_IDX);
        presc_nx    = tick ? '0 : presc + PS_W'(1);
        idx_nx      = idx;
        if (wrap) begin
            idx_nx = '0;
        end else if (tick) begin
            idx_nx = idx + IDX_W'(1);
        end
        sh_value_nx = wrap ? value : sh_value;
        sh_dp_nx    = wrap ? dp_in : sh_dp;
        sh_blank_nx = wrap ? blank : sh_blank;
        sh_lz_nx    = wrap ? lz_en : sh_lz;
    end

    // Blanking per digit: forced blank, or a leading zero when everything above is also zero
    always_comb begin
        digit_blank = sh_blank_nx;
        upper_zero  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (sh_value_nx[4*i +: 4] == 4'h0);
            if (sh_lz_nx && (i > 0) && upper_zero) begin
                digit_blank[i] = 1'b1;
            end
        end
    end

    assign nib_sel = sh_value_nx[4*idx_nx +: 4];

    seven_seg_hex_decoder u_decoder (
        .nibble (nib_sel),
        .glyph  (glyph)
    );

    // Output image for the state being entered, so outputs move on the same edge as the index
    always_comb begin
        an_nx  = AN_OFF;
        seg_nx = SEG_BLANK;
        dp_nx  = 1'b1;
        if (!(presc_nx < GUARD_PS) && !digit_blank[idx_nx]) begin
            an_nx[idx_nx] = 1'b0;
            seg_nx        = glyph;
            dp_nx         = ~sh_dp_nx[idx_nx];
        end
    end

    // State and output registers; reset drops everything dark immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc      <= '0;
            idx        <= '0;
            sh_value   <= '0;
            sh_dp      <= '0;
            sh_blank   <= '0;
            sh_lz      <= 1'b0;
            an         <= AN_OFF;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            presc      <= presc_nx;
            idx        <= idx_nx;
            sh_value   <= sh_value_nx;
            sh_dp      <= sh_dp_nx;
            sh_blank   <= sh_blank_nx;
            sh_lz      <= sh_lz_nx;
            an         <= an_nx;
            seg        <= seg_nx;
            dp         <= dp_nx;
            frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb/tb_seven_segment_scanner.sv - self-checking bench for seven_segment_scanner
module tb_seven_segment_scanner;

    localparam int N     = 4;
    localparam int P     = 4;
    localparam int G     = 1;
    localparam int FRAME = N * P;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  blank;
    logic        lz_en;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int n_cmp = 0;
    int n_err = 0;

    int          c;
    logic [15:0] m_value;
    logic [3:0]  m_dp;
    logic [3:0]  m_blank;
    logic        m_lz;

    logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seven_segment_scanner #(
        .NUM_DIGITS (N),
        .PRESCALE   (P),
        .GUARD      (G)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .value      (value),
        .dp_in      (dp_in),
        .blank      (blank),
        .lz_en      (lz_en),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_off(input string tag);
        check({tag, ".an"}, 32'(an), 32'hF);
        check({tag, ".seg"}, 32'(seg), 32'h7F);
        check({tag, ".dp"}, 32'(dp), 32'h1);
        check({tag, ".fd"}, 32'(frame_done), 32'h0);
    endtask

    task automatic model_reset();
        c       = 0;
        m_value = '0;
        m_dp    = '0;
        m_blank = '0;
        m_lz    = 1'b0;
    endtask

    // Expected display from elapsed cycles: slot = cycles / P, digit = slot mod N
    task automatic check_model();
        int          d;
        int          pos;
        logic [15:0] upper;
        logic        blanked;
        logic [3:0]  e_an;
        logic [6:0]  e_seg;
        logic        e_dp;
        logic        e_fd;
        d       = (c / P) % N;
        pos     = c % P;
        upper   = m_value >> (4 * d);
        blanked = m_blank[d] || (m_lz && (d > 0) && (upper == 16'h0));
        e_an    = 4'hF;
        e_seg   = 7'h7F;
        e_dp    = 1'b1;
        if (pos >= G && !blanked) begin
            e_an  = ~(4'b0001 << d);
            e_seg = glyph_tab[m_value[4*d +: 4]];
            e_dp  = ~m_dp[d];
        end
        e_fd = (c > 0) && (c % FRAME == 0);
        check($sformatf("model.an c=%0d", c), 32'(an), 32'(e_an));
        check($sformatf("model.seg c=%0d", c), 32'(seg), 32'(e_seg));
        check($sformatf("model.dp c=%0d", c), 32'(dp), 32'(e_dp));
        check($sformatf("model.fd c=%0d", c), 32'(frame_done), 32'(e_fd));
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            c++;
            if (c % FRAME == 0) begin
                m_value = value;
                m_dp    = dp_in;
                m_blank = blank;
                m_lz    = lz_en;
            end
            #1;
            check_model();
        end
    endtask

    task automatic run_to(input int phase);
        run(1);
        while (c % FRAME != phase) run(1);
    endtask

    initial begin
        reset = 1'b0;
        value = '0;
        dp_in = '0;
        blank = '0;
        lz_en = 1'b0;
        model_reset();

        #12;
        check_off("reset_hold");

        @(negedge clk);
        reset = 1'b1;
        value = 16'h1234;
        #1;
        check_model();

        run(1);
        check("pre_load.an", 32'(an), 32'hE);
        check("pre_load.seg", 32'(seg), 32'h40);

        run_to(0);
        check("wrap.fd", 32'(frame_done), 32'h1);
        run(1);
        check("d0.an", 32'(an), 32'hE);
        check("d0.seg", 32'(seg), 32'h19);
        run_to(5);
        check("d1.an", 32'(an), 32'hD);
        check("d1.seg", 32'(seg), 32'h30);

        value = 16'hABCD;
        run_to(13);
        check("d3_old.seg", 32'(seg), 32'h79);
        run_to(1);
        check("d0_new.seg", 32'(seg), 32'h21);
        run_to(0);

        value = 16'h0050;
        lz_en = 1'b1;
        run(2 * FRAME);
        value = 16'h0000;
        run(2 * FRAME);

        value = 16'h1234;
        lz_en = 1'b0;
        blank = 4'b0100;
        dp_in = 4'b0001;
        run(2 * FRAME);

        for (int f = 0; f < 12; f++) begin
            run($urandom_range(1, 20));
            value = 16'($urandom);
            dp_in = 4'($urandom);
            blank = 4'($urandom_range(0, 3) == 0 ? $urandom : 0);
            lz_en = 1'($urandom);
            if ($urandom_range(0, 2) == 0) value[15:8] = 8'h00;
        end
        run(FRAME);

        run_to(9);
        #2;
        reset = 1'b0;
        #1;
        check_off("async_reset");
        @(negedge clk);
        @(negedge clk);
        check_off("reset_held");
        reset = 1'b1;
        model_reset();
        value = 16'($urandom);
        lz_en = 1'b0;
        blank = '0;
        #1;
        check_model();
        run(3 * FRAME);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
